// File: rtl/muldiv_alu_sequencer.sv
// Multi-cycle RV32M MUL (low word) / DIVU / REMU controller.
// It holds no arithmetic of its own and borrows the execute-stage ALU while busy.
module muldiv_alu_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] OpA,
  input  logic [DATA_WIDTH-1:0] OpB,
  input  logic [DATA_WIDTH-1:0] AluResult,
  output logic [DATA_WIDTH-1:0] AluSrcA,
  output logic [DATA_WIDTH-1:0] AluSrcB,
  output logic [3:0]            AluControl,
  output logic                  AluOwn,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DCMP = 3'd2,
    DSUB = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  lt_q, lt_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [DATA_WIDTH-1:0] rs;
  assign rs = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      lt_q     <= 1'b0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      lt_q     <= lt_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    lt_d       = lt_q;
    count_d    = count_q;
    op_d       = op_q;
    result_d   = result_q;
    AluSrcA    = '0;
    AluSrcB    = '0;
    AluControl = ALU_ADD;
    AluOwn     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          acc_d    = '0;
          mcand_d  = OpA;
          mplier_d = OpB;
          rem_d    = '0;
          quo_d    = OpA;
          dvs_d    = OpB;
          lt_d     = 1'b0;
          count_d  = '0;
          op_d     = Op;
          // Divide-by-zero and the reserved op resolve without touching the ALU.
          unique case (Op)
            OP_MUL: state_d = MUL;
            OP_DIVU, OP_REMU: begin
              if (OpB != '0) begin
                state_d = DCMP;
              end else begin
                state_d  = DONE;
                result_d = (Op == OP_DIVU) ? '1 : OpA;
              end
            end
            default: begin
              state_d  = DONE;
              result_d = '0;
            end
          endcase
        end
      end

      MUL: begin
        Busy       = 1'b1;
        AluOwn     = 1'b1;
        AluSrcA    = acc_q;
        AluSrcB    = mplier_q[0] ? mcand_q : '0;
        AluControl = ALU_ADD;
        acc_d      = AluResult;
        mcand_d    = mcand_q << 1;
        mplier_d   = mplier_q >> 1;
        count_d    = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = DONE;
          result_d = AluResult;
        end
      end

      DCMP: begin
        Busy       = 1'b1;
        AluOwn     = 1'b1;
        AluSrcA    = rs;
        AluSrcB    = dvs_q;
        AluControl = ALU_SLTU;
        lt_d       = AluResult[0];
        state_d    = DSUB;
      end

      DSUB: begin
        Busy       = 1'b1;
        AluOwn     = 1'b1;
        AluSrcA    = rs;
        AluSrcB    = dvs_q;
        AluControl = ALU_SUB;
        rem_d      = lt_q ? rs : AluResult;
        quo_d      = {quo_q[DATA_WIDTH-2:0], ~lt_q};
        count_d    = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = DONE;
          result_d = (op_q == OP_DIVU) ? quo_d : rem_d;
        end else begin
          state_d  = DCMP;
        end
      end

      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Bench for muldiv_alu_sequencer: shared ALU model in the loop, results checked
// against plain-arithmetic expectations for directed and random operations.
module tb_muldiv_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB;
  logic [31:0] AluResult, AluSrcA, AluSrcB;
  logic [3:0]  AluControl;
  logic        AluOwn, Busy, Done;
  logic [31:0] Result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_alu_sequencer #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .Op         (Op),
    .OpA        (OpA),
    .OpB        (OpB),
    .AluResult  (AluResult),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluControl (AluControl),
    .AluOwn     (AluOwn),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result)
  );

  // Execute-stage ALU subset: add, sub, sltu.
  always_comb begin
    case (AluControl)
      4'b0000: AluResult = AluSrcA + AluSrcB;
      4'b0001: AluResult = AluSrcA - AluSrcB;
      4'b1001: AluResult = {31'd0, (AluSrcA < AluSrcB)};
      default: AluResult = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges after the accept edge until the cycle in which Done is visible.
  function automatic int ref_edges(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b00) return 32;
    if ((op == 2'b01 || op == 2'b10) && b != 0) return 64;
    return 0;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit perturb, input string tag);
    logic [31:0] exp, prev;
    int          k, busy_n, exp_k;
    bit          seq_ok;
    logic [3:0]  want_ctl;
    exp    = ref_result(op, a, b);
    exp_k  = ref_edges(op, b);
    prev   = Result;
    Start  = 1'b1;
    Op     = op;
    OpA    = a;
    OpB    = b;
    @(posedge clk); #1;
    if (!hold) Start = 1'b0;
    k      = 0;
    busy_n = 0;
    seq_ok = 1'b1;
    while (Done !== 1'b1 && k < 200) begin
      if (Busy === 1'b1) busy_n++;
      if (AluOwn !== Busy) seq_ok = 1'b0;
      if (Busy === 1'b1) begin
        if (op == 2'b00) want_ctl = 4'b0000;
        else want_ctl = (k % 2 == 0) ? 4'b1001 : 4'b0001;
        if (AluControl !== want_ctl) seq_ok = 1'b0;
      end
      if (k == 1) check({tag, "_result_held_during_op"}, Result, prev);
      if (perturb && k == 5) begin
        OpA = $urandom;
        OpB = $urandom;
        Op  = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_edges"}, 32'(k), 32'(exp_k));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_k));
    check({tag, "_alu_sequence"}, {31'd0, seq_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
    check({tag, "_own_at_done"}, {31'd0, AluOwn}, 32'd0);
    check({tag, "_result"}, Result, exp);
    Start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_single_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_idle_srca"}, AluSrcA, 32'd0);
    check({tag, "_idle_ctl"}, {28'd0, AluControl}, 32'd0);
    check({tag, "_result_hold"}, Result, exp);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst   = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    OpA   = '0;
    OpB   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, Busy},   32'd0);
    check("rst_done",   {31'd0, Done},   32'd0);
    check("rst_own",    {31'd0, AluOwn}, 32'd0);
    check("rst_result", Result,          32'd0);
    check("rst_srca",   AluSrcA,         32'd0);
    check("rst_srcb",   AluSrcB,         32'd0);
    check("rst_ctl",    {28'd0, AluControl}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'd7, 32'd6, 1'b0, 1'b0, "mul_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mul_ffff");
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, "mul_wrap");
    run_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, "remu_100_7");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_max_1");
    run_op(2'b01, 32'd5, 32'd0, 1'b0, 1'b0, "divu_by0");
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, "remu_by0");
    run_op(2'b11, 32'd9, 32'd3, 1'b0, 1'b0, "op_rsvd");
    run_op(2'b01, 32'd1000, 32'd33, 1'b1, 1'b1, "divu_hold_perturb");
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "mul_hold_perturb");

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    // Reset arriving in the tenth MUL cycle abandons the operation.
    Start = 1'b1;
    Op    = 2'b00;
    OpA   = 32'd9;
    OpB   = 32'd11;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",   {31'd0, Busy},   32'd0);
    check("midrst_own",    {31'd0, AluOwn}, 32'd0);
    check("midrst_result", Result,          32'd0);
    check("midrst_done",   {31'd0, Done},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", {31'd0, Done}, 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, "mul_3x5_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
